// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: ALU command codes,
// register constants and default datapath widths.
package mips_pkg;

    // Default widths
    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    // EXE-stage ALU commands
    localparam logic [3:0] EXE_NOP = 4'd0;
    localparam logic [3:0] EXE_ADD = 4'd1;
    localparam logic [3:0] EXE_SUB = 4'd2;
    localparam logic [3:0] EXE_AND = 4'd3;
    localparam logic [3:0] EXE_OR  = 4'd4;
    localparam logic [3:0] EXE_NOR = 4'd5;
    localparam logic [3:0] EXE_XOR = 4'd6;
    localparam logic [3:0] EXE_SLL = 4'd7;
    localparam logic [3:0] EXE_SLA = 4'd8;
    localparam logic [3:0] EXE_SRA = 4'd9;
    localparam logic [3:0] EXE_SRL = 4'd10;

    // $zero register index: writes to it are discarded, so it never creates a hazard
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_exe_pipe_reg_sat_counter.sv
// Saturating up-counter used for the debug performance counters.
// Counts on inc unless hold is asserted; sticks at all-ones.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          hold,
    output logic [CW-1:0] count
);

    // Increment until all-ones, never wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!hold && inc && (count != {CW{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register. Holds decoded operands/control for the EXE
// stage, inserts bubbles on flush or load-use hazard, freezes on stall,
// and keeps saturating bubble/stall counters for debug.
module id_exe_pipe_reg
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          flush,
    input  logic          idValid,
    input  logic [DW-1:0] idPc,
    input  logic [DW-1:0] idVal1,
    input  logic [DW-1:0] idVal2,
    input  logic [DW-1:0] idStVal,
    input  logic [RW-1:0] idSrc1,
    input  logic [RW-1:0] idSrc2,
    input  logic          idUsesSrc2,
    input  logic [RW-1:0] idDest,
    input  logic [3:0]    idExeCMD,
    input  logic          idMemRead,
    input  logic          idMemWrite,
    input  logic          idWbEn,
    output logic          exeValid,
    output logic [DW-1:0] exePc,
    output logic [DW-1:0] exeVal1,
    output logic [DW-1:0] exeVal2,
    output logic [DW-1:0] exeStVal,
    output logic [RW-1:0] exeSrc1,
    output logic [RW-1:0] exeSrc2,
    output logic [RW-1:0] exeDest,
    output logic [3:0]    exeCMD,
    output logic          exeMemRead,
    output logic          exeMemWrite,
    output logic          exeWbEn,
    output logic          hazard,
    output logic [CW-1:0] bubbleCnt,
    output logic [CW-1:0] stallCnt
);

    logic bubble;

    // Load-use detect: a load sitting in EXE whose destination the ID instruction reads
    always_comb begin
        hazard = idValid && exeValid && exeMemRead &&
                 (exeDest != RW'(REG_ZERO)) &&
                 ((idSrc1 == exeDest) || (idUsesSrc2 && (idSrc2 == exeDest)));
    end

    assign bubble = flush || hazard;

    // Pipe register update, priority rst > freeze > flush/hazard bubble > load
    always_ff @(posedge clk) begin
        if (rst || (!freeze && bubble)) begin
            // A bubble is an all-zero slot so it can have no side effects downstream
            exeValid    <= 1'b0;
            exePc       <= '0;
            exeVal1     <= '0;
            exeVal2     <= '0;
            exeStVal    <= '0;
            exeSrc1     <= '0;
            exeSrc2     <= '0;
            exeDest     <= '0;
            exeCMD      <= EXE_NOP;
            exeMemRead  <= 1'b0;
            exeMemWrite <= 1'b0;
            exeWbEn     <= 1'b0;
        end else if (!freeze) begin
            exeValid    <= idValid;
            exePc       <= idPc;
            exeVal1     <= idVal1;
            exeVal2     <= idVal2;
            exeStVal    <= idStVal;
            exeSrc1     <= idSrc1;
            exeSrc2     <= idSrc2;
            exeDest     <= idDest;
            // Invalid ID slots carry their data but must not act
            exeCMD      <= idValid ? idExeCMD : EXE_NOP;
            exeMemRead  <= idValid && idMemRead;
            exeMemWrite <= idValid && idMemWrite;
            exeWbEn     <= idValid && idWbEn;
        end
    end

    // One count per bubble cycle, even when flush and hazard coincide; frozen cycles don't count
    sat_counter #(.CW(CW)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble),
        .hold  (freeze),
        .count (bubbleCnt)
    );

    // Counts every frozen cycle
    sat_counter #(.CW(CW)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze),
        .hold  (1'b0),
        .count (stallCnt)
    );

endmodule
